// File: rtl/dummy_seq.sv
// dummy_seq: queued instruction sequencer that issues timed event pulses from WAIT instructions
module dummy_seq #(
  parameter int RESOURCE_INSTR_WIDTH = 27,
  parameter int ITER_WIDTH = 12,
  parameter int DELAY_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic instr_en,
  input  logic [RESOURCE_INSTR_WIDTH-1:0] instr,
  input  logic activate,
  output logic busy,
  output logic event_pulse,
  output logic done,
  output logic overflow,
  output logic bad_op
);
  localparam int RW = RESOURCE_INSTR_WIDTH;
  localparam int OPCODE_WIDTH = RESOURCE_INSTR_WIDTH - ITER_WIDTH - DELAY_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  if (OPCODE_WIDTH < 1) begin : g_chk_op
    $error("dummy_seq: opcode field width must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo
    $error("dummy_seq: FIFO_DEPTH must be a power of two >= 2");
  end
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, n_state;
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] cnt;
  logic [RW-1:0] exec, n_exec;
  logic [DELAY_WIDTH-1:0] dcnt, n_dcnt;
  logic [ITER_WIDTH-1:0] icnt, n_icnt;
  logic empty, full, is_wait, is_nop, fire, adv, pop, push, n_fire;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign is_wait = exec[RW-1 -: OPCODE_WIDTH] == OPCODE_WIDTH'(1);
  assign is_nop = exec[RW-1 -: OPCODE_WIDTH] == '0;
  assign fire = state == RUN && is_wait && dcnt == exec[DELAY_WIDTH-1:0];
  assign adv = state == RUN && (!is_wait || (fire && icnt == exec[DELAY_WIDTH +: ITER_WIDTH]));
  assign pop = !empty && ((state == IDLE && activate) || adv);
  assign push = instr_en && (!full || pop);
  // Events are registered, so fire is looked ahead on the next-state values; this makes delay=0 pulse on the RUN entry cycle
  assign n_fire = n_state == RUN && n_exec[RW-1 -: OPCODE_WIDTH] == OPCODE_WIDTH'(1) && n_dcnt == n_exec[DELAY_WIDTH-1:0];
  always_comb begin
    n_state = state;
    n_exec = exec;
    n_dcnt = dcnt;
    n_icnt = icnt;
    case (state)
      IDLE: begin
        n_dcnt = '0;
        n_icnt = '0;
        if (activate) begin
          n_state = empty ? FIN : RUN;
          n_exec = empty ? exec : mem[rd_ptr];
        end
      end
      RUN: begin
        if (adv) begin
          n_state = empty ? FIN : RUN;
          n_exec = empty ? exec : mem[rd_ptr];
          n_dcnt = '0;
          n_icnt = '0;
        end else if (fire) begin
          n_dcnt = '0;
          n_icnt = icnt + 1'b1;
        end else begin
          n_dcnt = dcnt + 1'b1;
        end
      end
      default: n_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      exec <= '0;
      dcnt <= '0;
      icnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      busy <= 1'b0;
      event_pulse <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      bad_op <= 1'b0;
    end else begin
      state <= n_state;
      exec <= n_exec;
      dcnt <= n_dcnt;
      icnt <= n_icnt;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      busy <= n_state == RUN;
      event_pulse <= n_fire;
      done <= n_state == FIN;
      overflow <= overflow | (instr_en & ~push);
      bad_op <= bad_op | (state == RUN && !is_wait && !is_nop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= instr;
  end
endmodule
